pe_mac_core: RTL and testbench
==============================

# pe_mac_core

Parametrised second-generation processing element: a multi-lane multiply-accumulate core with resident weight storage, configurable tap count, signed/unsigned arithmetic and saturating or wrapping accumulation. It replaces the fixed-size PE datapath inside the PE array. It is fed by the array's input and weight distribution over rdy/ack channels and returns one partial-sum vector per window to the psum collector.

## Interface
- LANES, 4, output lanes (psum rows); multiple of IN_CH
- IN_CH, 2, input channels; lane l reads channel l/(LANES/IN_CH)
- DWD, 8, input/weight width
- PSUMDWD, 16, psum/accumulator width; ≥ 2*DWD
- KDEPTH, 8, weight pad depth (max taps)
- WINWD, 8, window-count width
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- Conf_rdy  in  1  config valid
- Conf_ack  out  1  config accepted
- i_conf  in  PECoreConf  {k, is_signed, sat, windows}
- Weight_rdy / Weight_ack  in / out  1  weight beat handshake
- i_Weight  in  DWD×[LANES]  one tap of weights, all lanes
- Input_rdy / Input_ack  in / out  1  input beat handshake
- i_Input  in  DWD×[IN_CH]  one tap of inputs
- Psum_rdy / Psum_ack  out / in  1  psum handshake
- o_Psum  out  PSUMDWD×[LANES]  window result
- o_ovf  out  [LANES]  per-lane overflow seen in this window
- o_busy  out  1  state≠IDLE

## Operation
- Transfers happen on a cycle where rdy&&ack.
- States: IDLE, LOADW, COMPUTE, DRAIN.
- IDLE: Conf_ack=1. On a config transfer, latch the fields. k=0 means KDEPTH. Go to LOADW with the tap counter at 0.
- LOADW: Weight_ack=1. Beat n is written to pad address n. After k beats, go to COMPUTE.
- COMPUTE: Input_ack=1 while taps remain in the current window. Beat n is multiplied by pad[n] per lane. Products are registered, then added into the lane accumulator. The accumulator is cleared at the first tap of each window.
- After the k-th input is accepted, Input_ack drops and the state goes to DRAIN.
- DRAIN: when the last accumulate lands, copy the accumulators to o_Psum/o_ovf and raise Psum_rdy. Hold both until Psum_ack.
- On the psum transfer, windows_done increments. If windows_done equals windows (0 means 2^WINWD), go to IDLE. Otherwise return to COMPUTE. Weights stay resident.
- Arithmetic:
  - is_signed selects two's-complement versus zero extension of operands.
  - Products are 2*DWD bits, extended to PSUMDWD+1 before the add.
  - Overflow means the true sum falls outside the PSUMDWD range for the selected signedness.
  - With sat=1, the result clamps to max/min. With sat=0, it wraps.
  - o_ovf is sticky per window and is set in both modes.
- Ready/valid inputs are ignored outside their state: Conf outside IDLE, Weight outside LOADW, Input outside COMPUTE.
- A synchronous reset in any state goes to IDLE, clears counters, accumulators and the pad-valid state, and aborts any psum in flight.

## Timing
- Reset values:
  - Conf_ack=1 (IDLE).
  - Weight_ack=0, Input_ack=0, Psum_rdy=0, o_busy=0.
  - o_Psum all zeros, o_ovf=0.
- All acks and Psum_rdy are registered or state-decoded; none depend combinationally on the same-cycle rdy/ack of another port.
- Throughput: one tap per cycle in LOADW and COMPUTE.
- Latency: last input accepted at cycle t, product registered at t+1, accumulator at t+2, Psum_rdy=1 at t+2.
- The first input of the next window is accepted no earlier than the cycle after the psum transfer.
- Psum_ack held high: the psum transfers in the same cycle Psum_rdy rises. Back-pressure: o_Psum is stable until the transfer.
- LOADW→COMPUTE: the cycle after the k-th weight transfer, Input_ack=1.

## Structure
- Shared package pe_core_cfg holds:
  - the PECoreConf packed struct (k: $clog2(KDEPTH+1), is_signed, sat, windows: WINWD);
  - the state enum;
  - the default LANES/IN_CH/DWD/PSUMDWD/KDEPTH constants.
- Sub-module pe_mac_lane: one lane's multiply register, extended adder, sat/wrap clamp and ovf flag. It is instantiated LANES times by generate.
- The weight pad is a local register array, KDEPTH×LANES×DWD.

## Test plan
Defaults are used unless stated.
- Unsigned, k=3, windows=1:
  - Stimulus: weights all lanes 1,2,3; ch0 inputs 10,20,30; ch1 inputs 1,1,1.
  - Required: o_Psum={140,140,6,6}; Psum_rdy 2 cycles after the last Input transfer; IDLE after Psum_ack.
- Signed, k=1: weight 0xFE, input 100 → o_Psum=0xFF38 (−200), o_ovf=0.
- Signed, k=8 (conf k=0 path), weights 127, inputs 127 (true sum 129032):
  - sat=1 → 0x7FFF, o_ovf=1.
  - sat=0 → 0xF808, o_ovf=1.
- windows=2, k=2, Psum_ack held low 5 cycles:
  - Input_ack stays 0 and o_Psum stays stable.
  - The second window reuses the resident weights without a Weight beat.
  - Result: two psum transfers, then IDLE.
- Weight_rdy/Input_rdy asserted in IDLE, and Conf_rdy asserted in COMPUTE → no transfers occur and the state is unchanged.
- i_rst asserted for 1 cycle mid-COMPUTE (after tap 1 of 3):
  - Next cycle: IDLE, all outputs at reset values.
  - A fresh config and run then gives the correct, uncontaminated sum.

Source files
------------

// File: rtl/pe_mac_core_pkg.sv
// Shared definitions for the PE MAC core: default geometry, the config word
// and the controller state encoding.
package pe_core_cfg;

    localparam int LANES_DEF   = 4;
    localparam int IN_CH_DEF   = 2;
    localparam int DWD_DEF     = 8;
    localparam int PSUMDWD_DEF = 16;
    localparam int KDEPTH_DEF  = 8;
    localparam int WINWD_DEF   = 8;

    localparam int KW = $clog2(KDEPTH_DEF + 1);

    typedef struct packed {
        logic [KW-1:0]        k;
        logic                 is_signed;
        logic                 sat;
        logic [WINWD_DEF-1:0] windows;
    } PECoreConf;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADW   = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } pe_state_e;

endpackage

// File: rtl/pe_mac_core_lane.sv
// One MAC lane: registered product, extended accumulate, saturate/wrap clamp
// and a sticky per-window overflow flag.
module pe_mac_lane #(
    parameter int DWD     = 8,
    parameter int PSUMDWD = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_mul_en,
    input  logic               i_acc_en,
    input  logic               i_acc_clr,
    input  logic               i_is_signed,
    input  logic               i_sat,
    input  logic [DWD-1:0]     i_weight,
    input  logic [DWD-1:0]     i_input,
    output logic [PSUMDWD-1:0] o_acc_next,
    output logic               o_ovf_next
);

    localparam int PW = 2 * DWD;
    localparam int SW = PSUMDWD + 1;

    localparam logic [PSUMDWD-1:0] S_MAX = {1'b0, {(PSUMDWD-1){1'b1}}};
    localparam logic [PSUMDWD-1:0] S_MIN = {1'b1, {(PSUMDWD-1){1'b0}}};
    localparam logic [PSUMDWD-1:0] U_MAX = {PSUMDWD{1'b1}};

    logic signed [DWD:0]  w_ext, x_ext;
    logic signed [PW-1:0] prod_full;
    logic [PW-1:0]        prod_q, prod_d;
    logic [PSUMDWD-1:0]   acc_q, acc_d, acc_base;
    logic                 ovf_q, ovf_d, ovf_now;
    logic [SW-1:0]        prod_x, acc_x, sum;

    always_comb begin
        w_ext     = {i_is_signed & i_weight[DWD-1], i_weight};
        x_ext     = {i_is_signed & i_input[DWD-1], i_input};
        prod_full = PW'(w_ext) * PW'(x_ext);
        prod_d    = i_mul_en ? prod_full : prod_q;

        acc_base = i_acc_clr ? '0 : acc_q;
        prod_x   = {{(SW-PW){i_is_signed & prod_q[PW-1]}}, prod_q};
        acc_x    = {i_is_signed & acc_base[PSUMDWD-1], acc_base};
        sum      = acc_x + prod_x;

        // One guard bit is enough: both addends already fit the psum range.
        ovf_now = i_is_signed ? (sum[SW-1] != sum[SW-2]) : sum[SW-1];

        if (ovf_now && i_sat) begin
            o_acc_next = !i_is_signed ? U_MAX : (sum[SW-1] ? S_MIN : S_MAX);
        end else begin
            o_acc_next = sum[PSUMDWD-1:0];
        end
        o_ovf_next = (i_acc_clr ? 1'b0 : ovf_q) | ovf_now;

        acc_d = i_acc_en ? o_acc_next : acc_q;
        ovf_d = i_acc_en ? o_ovf_next : ovf_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prod_q <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: rtl/pe_mac_core.sv
// Multi-lane MAC processing element: loads a resident weight pad, then runs
// one or more windows of k taps, returning a psum vector per window.
module pe_mac_core
    import pe_core_cfg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int IN_CH   = IN_CH_DEF,
    parameter int DWD     = DWD_DEF,
    parameter int PSUMDWD = PSUMDWD_DEF,
    parameter int KDEPTH  = KDEPTH_DEF,
    parameter int WINWD   = WINWD_DEF
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            Conf_rdy,
    output logic                            Conf_ack,
    input  PECoreConf                       i_conf,
    input  logic                            Weight_rdy,
    output logic                            Weight_ack,
    input  logic [LANES-1:0][DWD-1:0]       i_Weight,
    input  logic                            Input_rdy,
    output logic                            Input_ack,
    input  logic [IN_CH-1:0][DWD-1:0]       i_Input,
    output logic                            Psum_rdy,
    input  logic                            Psum_ack,
    output logic [LANES-1:0][PSUMDWD-1:0]   o_Psum,
    output logic [LANES-1:0]                o_ovf,
    output logic                            o_busy
);

    localparam int GRP = LANES / IN_CH;
    localparam int AW  = (KDEPTH > 1) ? $clog2(KDEPTH) : 1;

    pe_state_e state_q, state_d;
    logic [KW-1:0]    tap_q, tap_d, k_q, k_d;
    logic             is_signed_q, is_signed_d, sat_q, sat_d;
    logic [WINWD-1:0] windows_q, windows_d, win_done_q, win_done_d, win_next;
    logic             conf_ack_q, conf_ack_d, weight_ack_q, weight_ack_d;
    logic             input_ack_q, input_ack_d, psum_rdy_q, psum_rdy_d;
    logic             busy_q, busy_d;
    logic             mul_valid_q, mul_valid_d, mul_first_q, mul_first_d;
    logic             mul_last_q, mul_last_d;
    logic [LANES-1:0][PSUMDWD-1:0] psum_q, psum_d, acc_next;
    logic [LANES-1:0] ovf_q, ovf_d, ovf_next;
    logic [LANES-1:0][DWD-1:0] pad_q [KDEPTH];
    logic [LANES-1:0][DWD-1:0] pad_d [KDEPTH];
    logic [AW-1:0]    tap_addr;
    logic             tap_last, input_xfer;

    assign tap_addr   = tap_q[AW-1:0];
    assign tap_last   = (tap_q == k_q - KW'(1));
    assign input_xfer = Input_rdy && input_ack_q;
    assign win_next   = win_done_q + WINWD'(1);

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        k_d         = k_q;
        is_signed_d = is_signed_q;
        sat_d       = sat_q;
        windows_d   = windows_q;
        win_done_d  = win_done_q;
        pad_d       = pad_q;
        mul_valid_d = 1'b0;
        mul_first_d = 1'b0;
        mul_last_d  = 1'b0;
        psum_d      = psum_q;
        ovf_d       = ovf_q;
        psum_rdy_d  = psum_rdy_q;

        case (state_q)
            IDLE: begin
                if (Conf_rdy && conf_ack_q) begin
                    k_d         = (i_conf.k == '0) ? KW'(KDEPTH) : i_conf.k;
                    is_signed_d = i_conf.is_signed;
                    sat_d       = i_conf.sat;
                    windows_d   = i_conf.windows;
                    win_done_d  = '0;
                    tap_d       = '0;
                    state_d     = LOADW;
                end
            end
            LOADW: begin
                if (Weight_rdy && weight_ack_q) begin
                    pad_d[tap_addr] = i_Weight;
                    tap_d   = tap_last ? '0 : tap_q + KW'(1);
                    state_d = tap_last ? COMPUTE : LOADW;
                end
            end
            COMPUTE: begin
                if (input_xfer) begin
                    mul_valid_d = 1'b1;
                    mul_first_d = (tap_q == '0);
                    mul_last_d  = tap_last;
                    tap_d       = tap_last ? '0 : tap_q + KW'(1);
                    state_d     = tap_last ? DRAIN : COMPUTE;
                end
            end
            DRAIN: begin
                if (psum_rdy_q && Psum_ack) begin
                    psum_rdy_d = 1'b0;
                    win_done_d = win_next;
                    // windows==0 wraps the counter back to 0 after 2^WINWD windows.
                    state_d    = (win_next == windows_q) ? IDLE : COMPUTE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (mul_valid_q && mul_last_q) begin
            psum_d     = acc_next;
            ovf_d      = ovf_next;
            psum_rdy_d = 1'b1;
        end

        conf_ack_d   = (state_d == IDLE);
        weight_ack_d = (state_d == LOADW);
        input_ack_d  = (state_d == COMPUTE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= IDLE;
            tap_q        <= '0;
            k_q          <= '0;
            is_signed_q  <= 1'b0;
            sat_q        <= 1'b0;
            windows_q    <= '0;
            win_done_q   <= '0;
            conf_ack_q   <= 1'b1;
            weight_ack_q <= 1'b0;
            input_ack_q  <= 1'b0;
            psum_rdy_q   <= 1'b0;
            busy_q       <= 1'b0;
            mul_valid_q  <= 1'b0;
            mul_first_q  <= 1'b0;
            mul_last_q   <= 1'b0;
            psum_q       <= '0;
            ovf_q        <= '0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            k_q          <= k_d;
            is_signed_q  <= is_signed_d;
            sat_q        <= sat_d;
            windows_q    <= windows_d;
            win_done_q   <= win_done_d;
            conf_ack_q   <= conf_ack_d;
            weight_ack_q <= weight_ack_d;
            input_ack_q  <= input_ack_d;
            psum_rdy_q   <= psum_rdy_d;
            busy_q       <= busy_d;
            mul_valid_q  <= mul_valid_d;
            mul_first_q  <= mul_first_d;
            mul_last_q   <= mul_last_d;
            psum_q       <= psum_d;
            ovf_q        <= ovf_d;
        end
    end

    // Weight contents need no reset: every run reloads the pad before computing.
    always_ff @(posedge i_clk) begin
        pad_q <= pad_d;
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        pe_mac_lane #(
            .DWD     (DWD),
            .PSUMDWD (PSUMDWD)
        ) u_lane (
            .i_clk       (i_clk),
            .i_rst       (i_rst),
            .i_mul_en    (input_xfer),
            .i_acc_en    (mul_valid_q),
            .i_acc_clr   (mul_first_q),
            .i_is_signed (is_signed_q),
            .i_sat       (sat_q),
            .i_weight    (pad_q[tap_addr][l]),
            .i_input     (i_Input[l / GRP]),
            .o_acc_next  (acc_next[l]),
            .o_ovf_next  (ovf_next[l])
        );
    end

    assign Conf_ack   = conf_ack_q;
    assign Weight_ack = weight_ack_q;
    assign Input_ack  = input_ack_q;
    assign Psum_rdy   = psum_rdy_q;
    assign o_Psum     = psum_q;
    assign o_ovf      = ovf_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_pe_mac_core.sv
// Directed self-checking bench for pe_mac_core with hand-computed results.
module tb_pe_mac_core;
    import pe_core_cfg::*;

    localparam int LANES   = 4;
    localparam int IN_CH   = 2;
    localparam int DWD     = 8;
    localparam int PSUMDWD = 16;

    logic                          i_clk = 1'b0;
    logic                          i_rst = 1'b1;
    logic                          Conf_rdy = 1'b0;
    logic                          Conf_ack;
    PECoreConf                     i_conf = '0;
    logic                          Weight_rdy = 1'b0;
    logic                          Weight_ack;
    logic [LANES-1:0][DWD-1:0]     i_Weight = '0;
    logic                          Input_rdy = 1'b0;
    logic                          Input_ack;
    logic [IN_CH-1:0][DWD-1:0]     i_Input = '0;
    logic                          Psum_rdy;
    logic                          Psum_ack = 1'b0;
    logic [LANES-1:0][PSUMDWD-1:0] o_Psum;
    logic [LANES-1:0]              o_ovf;
    logic                          o_busy;

    int nChecks = 0;
    int nFail   = 0;

    always #5 i_clk = ~i_clk;

    pe_mac_core dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .Conf_rdy   (Conf_rdy),
        .Conf_ack   (Conf_ack),
        .i_conf     (i_conf),
        .Weight_rdy (Weight_rdy),
        .Weight_ack (Weight_ack),
        .i_Weight   (i_Weight),
        .Input_rdy  (Input_rdy),
        .Input_ack  (Input_ack),
        .i_Input    (i_Input),
        .Psum_rdy   (Psum_rdy),
        .Psum_ack   (Psum_ack),
        .o_Psum     (o_Psum),
        .o_ovf      (o_ovf),
        .o_busy     (o_busy)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkOutput(tag, 64'(obs), 64'(exp));
    endtask

    // Hold rdy on one channel (0 conf, 1 weight, 2 input) until it transfers.
    task automatic applyStimulus(input int chan, input string tag);
        int   cycles = 0;
        logic done = 1'b0;
        case (chan)
            0:       Conf_rdy   = 1'b1;
            1:       Weight_rdy = 1'b1;
            default: Input_rdy  = 1'b1;
        endcase
        while (!done && cycles < 20) begin
            done = (chan == 0) ? Conf_ack : (chan == 1) ? Weight_ack : Input_ack;
            tick();
            cycles++;
        end
        Conf_rdy   = 1'b0;
        Weight_rdy = 1'b0;
        Input_rdy  = 1'b0;
        checkBit({tag, " transfer"}, done, 1'b1);
    endtask

    task automatic configure(input logic [KW-1:0] k, input logic sgn, input logic sat,
                             input logic [7:0] win, input string tag);
        i_conf.k         = k;
        i_conf.is_signed = sgn;
        i_conf.sat       = sat;
        i_conf.windows   = win;
        applyStimulus(0, tag);
    endtask

    task automatic sendWeight(input logic [7:0] w, input string tag);
        i_Weight = {LANES{w}};
        applyStimulus(1, tag);
    endtask

    task automatic sendInput(input logic [7:0] c0, input logic [7:0] c1, input string tag);
        i_Input = {c1, c0};
        applyStimulus(2, tag);
    endtask

    task automatic waitPsum(input string tag);
        int n = 0;
        while (Psum_rdy !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checkBit({tag, " psum_rdy"}, Psum_rdy, 1'b1);
    endtask

    task automatic checkPsum(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3, input logic [3:0] eOvf);
        logic [3:0][15:0] e;
        e = {e3, e2, e1, e0};
        for (int l = 0; l < LANES; l++) begin
            checkOutput($sformatf("%s psum[%0d]", tag, l), 64'(o_Psum[l]), 64'(e[l]));
        end
        checkOutput({tag, " ovf"}, 64'(o_ovf), 64'(eOvf));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        // Reset values
        tick();
        tick();
        checkBit("rst conf_ack", Conf_ack, 1'b1);
        checkBit("rst weight_ack", Weight_ack, 1'b0);
        checkBit("rst input_ack", Input_ack, 1'b0);
        checkBit("rst psum_rdy", Psum_rdy, 1'b0);
        checkBit("rst busy", o_busy, 1'b0);
        checkOutput("rst psum", 64'(o_Psum), 64'd0);
        checkOutput("rst ovf", 64'(o_ovf), 64'd0);
        i_rst = 1'b0;
        tick();

        // Unsigned k=3, latency and return to IDLE
        configure(4'd3, 1'b0, 1'b0, 8'd1, "t1 conf");
        checkBit("t1 weight_ack in LOADW", Weight_ack, 1'b1);
        checkBit("t1 conf_ack in LOADW", Conf_ack, 1'b0);
        checkBit("t1 busy", o_busy, 1'b1);
        sendWeight(8'd1, "t1 w0");
        sendWeight(8'd2, "t1 w1");
        sendWeight(8'd3, "t1 w2");
        checkBit("t1 input_ack after LOADW", Input_ack, 1'b1);
        sendInput(8'd10, 8'd1, "t1 in0");
        sendInput(8'd20, 8'd1, "t1 in1");
        sendInput(8'd30, 8'd1, "t1 in2");
        checkBit("t1 input_ack dropped", Input_ack, 1'b0);
        checkBit("t1 psum_rdy at t+1", Psum_rdy, 1'b0);
        Psum_ack = 1'b1;
        tick();
        checkBit("t1 psum_rdy at t+2", Psum_rdy, 1'b1);
        checkPsum("t1", 16'd140, 16'd140, 16'd6, 16'd6, 4'h0);
        tick();
        Psum_ack = 1'b0;
        checkBit("t1 idle conf_ack", Conf_ack, 1'b1);
        checkBit("t1 idle busy", o_busy, 1'b0);
        checkBit("t1 idle psum_rdy", Psum_rdy, 1'b0);

        // Signed k=1: -2 * 100
        configure(4'd1, 1'b1, 1'b0, 8'd1, "t2 conf");
        sendWeight(8'hFE, "t2 w0");
        sendInput(8'd100, 8'd100, "t2 in0");
        Psum_ack = 1'b1;
        waitPsum("t2");
        checkPsum("t2", 16'hFF38, 16'hFF38, 16'hFF38, 16'hFF38, 4'h0);
        tick();
        Psum_ack = 1'b0;
        checkBit("t2 idle", Conf_ack, 1'b1);

        // Signed k=0 (eight taps) 127*127: saturate then wrap
        for (int s = 1; s >= 0; s--) begin
            configure(4'd0, 1'b1, s[0], 8'd1, "t3 conf");
            for (int i = 0; i < 8; i++) sendWeight(8'd127, "t3 w");
            for (int i = 0; i < 8; i++) sendInput(8'd127, 8'd127, "t3 in");
            Psum_ack = 1'b1;
            waitPsum("t3");
            if (s == 1) checkPsum("t3 sat", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'hF);
            else        checkPsum("t3 wrap", 16'hF808, 16'hF808, 16'hF808, 16'hF808, 4'hF);
            tick();
            Psum_ack = 1'b0;
        end

        // Two windows, k=2, back-pressured psum, resident weights
        configure(4'd2, 1'b0, 1'b0, 8'd2, "t5 conf");
        sendWeight(8'd3, "t5 w0");
        sendWeight(8'd4, "t5 w1");
        sendInput(8'd5, 8'd1, "t5 a0");
        sendInput(8'd6, 8'd2, "t5 a1");
        waitPsum("t5 win1");
        for (int i = 0; i < 5; i++) begin
            checkBit($sformatf("t5 hold%0d input_ack", i), Input_ack, 1'b0);
            checkOutput($sformatf("t5 hold%0d psum", i), 64'(o_Psum),
                        64'({16'd11, 16'd11, 16'd39, 16'd39}));
            tick();
        end
        Psum_ack = 1'b1;
        tick();
        Psum_ack = 1'b0;
        checkBit("t5 back to compute", Input_ack, 1'b1);
        checkBit("t5 no weight phase", Weight_ack, 1'b0);
        checkBit("t5 psum_rdy cleared", Psum_rdy, 1'b0);
        sendInput(8'd2, 8'd0, "t5 b0");
        sendInput(8'd2, 8'd1, "t5 b1");
        Psum_ack = 1'b1;
        waitPsum("t5 win2");
        checkPsum("t5 win2", 16'd14, 16'd14, 16'd4, 16'd4, 4'h0);
        tick();
        Psum_ack = 1'b0;
        checkBit("t5 idle conf_ack", Conf_ack, 1'b1);
        checkBit("t5 idle busy", o_busy, 1'b0);

        // Handshakes offered in the wrong state are ignored
        Weight_rdy = 1'b1;
        Input_rdy  = 1'b1;
        tick();
        tick();
        checkBit("t6 idle weight_ack", Weight_ack, 1'b0);
        checkBit("t6 idle input_ack", Input_ack, 1'b0);
        checkBit("t6 idle busy", o_busy, 1'b0);
        Weight_rdy = 1'b0;
        Input_rdy  = 1'b0;
        configure(4'd3, 1'b0, 1'b0, 8'd1, "t6 conf");
        for (int i = 0; i < 3; i++) sendWeight(8'd5, "t6 w");
        i_conf.k   = 4'd1;
        Conf_rdy   = 1'b1;
        Weight_rdy = 1'b1;
        tick();
        tick();
        checkBit("t6 compute input_ack", Input_ack, 1'b1);
        checkBit("t6 compute conf_ack", Conf_ack, 1'b0);
        checkBit("t6 compute busy", o_busy, 1'b1);
        Conf_rdy   = 1'b0;
        Weight_rdy = 1'b0;

        // Reset mid-COMPUTE after one tap, then a clean run
        sendInput(8'd50, 8'd50, "t7 tap1");
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checkBit("t7 conf_ack", Conf_ack, 1'b1);
        checkBit("t7 weight_ack", Weight_ack, 1'b0);
        checkBit("t7 input_ack", Input_ack, 1'b0);
        checkBit("t7 psum_rdy", Psum_rdy, 1'b0);
        checkBit("t7 busy", o_busy, 1'b0);
        checkOutput("t7 psum", 64'(o_Psum), 64'd0);
        checkOutput("t7 ovf", 64'(o_ovf), 64'd0);
        configure(4'd2, 1'b0, 1'b0, 8'd1, "t7 conf");
        sendWeight(8'd1, "t7 w0");
        sendWeight(8'd2, "t7 w1");
        sendInput(8'd7, 8'd9, "t7 in0");
        sendInput(8'd8, 8'd10, "t7 in1");
        Psum_ack = 1'b1;
        waitPsum("t7");
        checkPsum("t7", 16'd23, 16'd23, 16'd29, 16'd29, 4'h0);
        tick();
        Psum_ack = 1'b0;
        checkBit("t7 idle", Conf_ack, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
